// File: rtl/sisa_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, STATUS register and
// sticky overflow flag.
module sisa_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        txd,
    output logic        irq
);

    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = AddrW + 1;
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e             state_q;
    logic [BaudW-1:0]   baud_q;
    logic [2:0]         bit_q;
    logic [7:0]         shift_q;
    logic               txd_q;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [AddrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        rdata_q;

    logic               full, empty, push, pop, baud_end;
    logic               ovf_set, ovf_clr;
    logic [7:0]         cnt_disp;
    logic [31:0]        status;
    logic               unused_wdata;

    assign unused_wdata = ^avs_writedata[31:8];

    assign full     = (count_q == CntFull);
    assign empty    = (count_q == '0);
    assign baud_end = (baud_q == BaudLast);
    // Full is judged on the pre-pop count, so a write racing a pop is still dropped.
    assign push     = avs_write && (avs_address == 2'd0) && !full;
    assign pop      = !empty && ((state_q == StIdle) || ((state_q == StStop) && baud_end));
    assign ovf_set  = avs_write && (avs_address == 2'd0) && full;
    assign ovf_clr  = avs_write && (avs_address == 2'd1) && avs_writedata[3];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        cnt_disp = (32'(count_q) > 32'd255) ? 8'hFF : 8'(count_q);
        status   = {20'd0, cnt_disp, ovf_q, (state_q != StIdle), empty, full};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= avs_writedata[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AddrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AddrW'(1);
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (avs_read) begin
            rdata_q <= (avs_address == 2'd1) ? status : 32'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        bit_q   <= '0;
                        baud_q  <= '0;
                        txd_q   <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                StData: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            shift_q <= shift_q >> 1;
                            txd_q   <= shift_q[1];
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        // Chain straight into the next start bit when data is waiting.
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            bit_q   <= '0;
                            txd_q   <= 1'b0;
                            state_q <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign txd          = txd_q;
    assign irq          = empty && (state_q == StIdle);
    assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_sisa_uart_tx.sv
// Scoreboard bench for sisa_uart_tx: a line receiver decodes frames and checks
// them against bytes queued when the bus writes were accepted.
module tb_sisa_uart_tx;

    localparam int unsigned Cpb   = 4;
    localparam int unsigned Depth = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        txd;
    logic        irq;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int rx_frames = 0;
    int start_q[$];
    logic [7:0] exp_q[$];

    sisa_uart_tx #(
        .CLKS_PER_BIT(Cpb),
        .FIFO_DEPTH  (Depth)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .avs_address  (avs_address),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .txd          (txd),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    // Line receiver: samples mid-bit on falling edges.
    initial begin : monitor
        bit         rx_on;
        int         rx_t;
        int         idx;
        logic [7:0] rx_byte;
        logic [7:0] exp_b;
        rx_on = 1'b0;
        rx_t = 0;
        rx_byte = 8'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                rx_on = 1'b0;
            end else begin
                if (!rx_on) begin
                    if (txd === 1'b0) begin
                        rx_on = 1'b1;
                        rx_t = 0;
                        start_q.push_back(cyc);
                    end
                end else begin
                    rx_t++;
                end
                if (rx_on && (rx_t % Cpb == Cpb / 2)) begin
                    idx = rx_t / Cpb;
                    if (idx == 0) begin
                        n_checks++;
                        if (txd !== 1'b0) begin
                            n_fail++;
                            $display("FAIL rx_start_bit: got %b want 0", txd);
                        end
                    end else if (idx <= 8) begin
                        rx_byte[idx-1] = txd;
                    end else begin
                        n_checks++;
                        if (txd !== 1'b1) begin
                            n_fail++;
                            $display("FAIL rx_stop_bit: got %b want 1", txd);
                        end
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL rx_frame: got byte %02h, none expected", rx_byte);
                        end else begin
                            exp_b = exp_q.pop_front();
                            if (rx_byte !== exp_b) begin
                                n_fail++;
                                $display("FAIL rx_frame: got %02h want %02h", rx_byte, exp_b);
                            end
                        end
                        rx_frames++;
                        rx_on = 1'b0;
                    end
                end
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input bit accept);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        if (a == 2'd0 && accept) exp_q.push_back(d[7:0]);
        @(posedge clk);
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: irq=%b after %0d cycles, want 1", name, irq, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL reset_irq: got %b want 1", irq); end
        n_checks++;
        if (avs_readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_readdata: got %08h want 0", avs_readdata);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Write issued on the first edge after reset release.
    task automatic test_single();
        logic [9:0] pat;
        pat = {1'b1, 8'h55, 1'b0};
        bus_write(2'd0, 32'hABCD_0055, 1'b1);
        n_checks++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL single_pre_start: got %b want 1", txd); end
        for (int i = 0; i < 10 * Cpb; i++) begin
            @(negedge clk);
            n_checks++;
            if (txd !== pat[i / Cpb]) begin
                n_fail++;
                $display("FAIL single_bit%0d_cyc%0d: got %b want %b", i / Cpb, i, txd, pat[i / Cpb]);
            end
            if (i == 20 || i == 10 * Cpb - 1) begin
                n_checks++;
                if (irq !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_irq_busy_cyc%0d: got %b want 0", i, irq);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b1 || txd !== 1'b1) begin
            n_fail++;
            $display("FAIL single_end: got irq=%b txd=%b want 1,1", irq, txd);
        end
    endtask

    task automatic test_back_to_back();
        int fb, sb;
        logic [31:0] v;
        fb = rx_frames;
        sb = start_q.size();
        bus_write(2'd0, 32'h0000_00A5, 1'b1);
        bus_write(2'd0, 32'h0000_003C, 1'b1);
        for (int i = 0; i < 76; i++) begin
            bus_read(2'd1, v);
            n_checks++;
            if (v[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_busy_read%0d: got status %08h want busy=1", i, v);
            end
        end
        wait_idle(200, "b2b");
        n_checks++;
        if (rx_frames - fb != 2) begin
            n_fail++;
            $display("FAIL b2b_frames: got %0d want 2", rx_frames - fb);
        end else begin
            n_checks++;
            if (start_q[sb+1] - start_q[sb] != 10 * Cpb) begin
                n_fail++;
                $display("FAIL b2b_gap: got %0d cycles between starts want %0d",
                         start_q[sb+1] - start_q[sb], 10 * Cpb);
            end
        end
    endtask

    task automatic test_overflow();
        int fb;
        logic [31:0] v;
        fb = rx_frames;
        for (int i = 1; i <= 6; i++) begin
            bus_write(2'd0, 32'(i), (i <= 5));
        end
        bus_read(2'd1, v);
        n_checks++;
        if (v !== 32'h0000_004D) begin
            n_fail++;
            $display("FAIL ovf_status: got %08h want 0000004d", v);
        end
        bus_write(2'd1, 32'h0000_0008, 1'b0);
        bus_read(2'd1, v);
        n_checks++;
        if (v !== 32'h0000_0045) begin
            n_fail++;
            $display("FAIL ovf_clear_status: got %08h want 00000045", v);
        end
        wait_idle(6 * 10 * Cpb + 40, "ovf");
        n_checks++;
        if (rx_frames - fb != 5) begin
            n_fail++;
            $display("FAIL ovf_frames: got %0d want 5", rx_frames - fb);
        end
    endtask

    task automatic test_read_latency();
        logic [31:0] v;
        bus_read(2'd1, v);
        n_checks++;
        if (v !== 32'h0000_0002) begin
            n_fail++;
            $display("FAIL rd_idle_status: got %08h want 00000002", v);
        end
        bus_write(2'd0, 32'h0000_005A, 1'b1);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (avs_readdata !== 32'h0000_0002) begin
                n_fail++;
                $display("FAIL rd_hold%0d: got %08h want 00000002", i, avs_readdata);
            end
            @(negedge clk);
        end
        bus_read(2'd2, v);
        n_checks++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL rd_addr2: got %08h want 0", v); end
        bus_read(2'd0, v);
        n_checks++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL rd_addr0: got %08h want 0", v); end
        avs_address = 2'd1;
        avs_read    = 1'b1;
        #1;
        n_checks++;
        if (avs_readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rd_before_edge: got %08h want 0", avs_readdata);
        end
        @(posedge clk);
        @(negedge clk);
        avs_read = 1'b0;
        n_checks++;
        if (avs_readdata !== 32'h0000_0006) begin
            n_fail++;
            $display("FAIL rd_after_edge: got %08h want 00000006", avs_readdata);
        end
        wait_idle(60, "rd");
    endtask

    task automatic test_reset_mid_frame();
        int sb, lows;
        logic [31:0] v;
        bus_write(2'd0, 32'h0000_00FF, 1'b1);
        bus_write(2'd0, 32'h0000_0011, 1'b1);
        bus_write(2'd0, 32'h0000_0022, 1'b1);
        repeat (15) @(negedge clk);
        bus_read(2'd1, v);
        n_checks++;
        if (v !== 32'h0000_0024) begin
            n_fail++;
            $display("FAIL rst_mid_status: got %08h want 00000024", v);
        end
        reset = 1'b1;
        #1;
        exp_q.delete();
        n_checks++;
        if (txd !== 1'b1 || irq !== 1'b1 || avs_readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_immediate: got txd=%b irq=%b rdata=%08h want 1,1,0",
                     txd, irq, avs_readdata);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb = start_q.size();
        bus_read(2'd1, v);
        n_checks++;
        if (v !== 32'h0000_0002) begin
            n_fail++;
            $display("FAIL rst_mid_after_status: got %08h want 00000002", v);
        end
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        n_checks++;
        if (lows != 0 || start_q.size() != sb) begin
            n_fail++;
            $display("FAIL rst_mid_no_frames: got %0d low cycles, %0d starts want 0,0",
                     lows, start_q.size() - sb);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_read_latency();
        test_reset_mid_frame();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
